// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NREQ requesters.
// Each granted operation is captured into a single response register and held until it is consumed.
module alu_share_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*XLEN-1:0] req_a,
  input  logic [NREQ*XLEN-1:0] req_b,
  input  logic [NREQ*4-1:0]    req_sel,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [XLEN-1:0]      rsp_res,
  output logic [XLEN-1:0]      alu_a,
  output logic [XLEN-1:0]      alu_b,
  output logic [3:0]           alu_sel,
  input  logic [XLEN-1:0]      alu_res
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_HOLD = 1'b1;

  logic            state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [XLEN-1:0] rsp_res_q, rsp_res_d;

  logic            can_grant;
  logic            grant_vld;
  logic [IW-1:0]   grant_idx;
  int unsigned     gsel;

  // A held result frees the slot on the same edge it is consumed, so a new
  // grant can overlap the consume and sustain one op per cycle.
  always_comb begin
    logic [IW-1:0] cand;
    cand      = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    can_grant = !rst && ((state_q == ST_IDLE) || rsp_ready[owner_q]);
    if (can_grant) begin
      for (int unsigned k = 1; k <= NREQ; k++) begin
        cand = IW'((32'(rr_ptr_q) + k) % NREQ);
        if (!grant_vld && req_valid[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  assign gsel = 32'(grant_idx);

  always_comb begin
    req_ready = '0;
    alu_a     = '0;
    alu_b     = '0;
    alu_sel   = '0;
    if (grant_vld) begin
      req_ready = NREQ'(1) << grant_idx;
      alu_a     = req_a[gsel*XLEN +: XLEN];
      alu_b     = req_b[gsel*XLEN +: XLEN];
      alu_sel   = req_sel[gsel*4 +: 4];
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    rsp_res_d = rsp_res_q;
    if (grant_vld) begin
      state_d   = ST_HOLD;
      owner_d   = grant_idx;
      rr_ptr_d  = grant_idx;
      rsp_res_d = alu_res;
    end else if (state_q == ST_HOLD && rsp_ready[owner_q]) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= IW'(NREQ - 1);
      rsp_res_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      rsp_res_q <= rsp_res_d;
    end
  end

  assign rsp_valid = (state_q == ST_HOLD) ? (NREQ'(1) << owner_q) : '0;
  assign rsp_res   = rsp_res_q;

endmodule
